anita3_trigger_scheduler: RTL and testbench

//  Arbitrates the four trigger sources (RF L3, PPS1, PPS2, software) onto the buffer handler trig input.

---
 rtl/anita3_trig_pkg.sv | 20 ++
 rtl/anita3_trigger_scheduler_if.sv | 28 ++
 rtl/anita3_sat_counter.sv | 27 ++
 rtl/anita3_trigger_scheduler.sv | 116 +++++++++++
 tb/tb_anita3_trigger_scheduler.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/anita3_trig_pkg.sv
// Shared definitions for the ANITA-3 trigger scheduler slice.
//   TRIG_*          source indices on trig_i / trig_o (0 = highest priority)
//   QUEUE_MASK_DEF  default set of sources held pending rather than dropped
//   state_t         scheduler FSM states
package anita3_trig_pkg;

  localparam int unsigned TRIG_RF   = 0;
  localparam int unsigned TRIG_PPS1 = 1;
  localparam int unsigned TRIG_PPS2 = 2;
  localparam int unsigned TRIG_SOFT = 3;

  localparam logic [3:0] QUEUE_MASK_DEF = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLDOFF
  } state_t;

endpackage

// File: rtl/anita3_trigger_scheduler_if.sv
// Trigger-path bundle between the trigger sources and the scheduler.
//   slave  : scheduler side (takes requests, drives trig_o/source_o/pending_o/busy_o)
//   master : source / buffer-handler side
interface anita3_trigger_scheduler_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned HOLD_W  = 16
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] trig_i;
  logic [NUM_SRC-1:0] src_en_i;
  logic [HOLD_W-1:0]  holdoff_i;
  logic               dead_i;
  logic [NUM_SRC-1:0] trig_o;
  logic [SRC_W-1:0]   source_o;
  logic [NUM_SRC-1:0] pending_o;
  logic               busy_o;

  modport slave (
    input  trig_i, src_en_i, holdoff_i, dead_i,
    output trig_o, source_o, pending_o, busy_o
  );

  modport master (
    output trig_i, src_en_i, holdoff_i, dead_i,
    input  trig_o, source_o, pending_o, busy_o
  );
endinterface

// File: rtl/anita3_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   inc_i    increment request
//   clr_i    synchronous clear
//   cnt_o    count, sticks at all-ones
module anita3_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/anita3_trigger_scheduler.sv
// Arbitrates RF/PPS1/PPS2/soft trigger requests onto the buffer-handler trig
// input: one trigger per issue slot, programmable holdoff, dead-time gating,
// queueing of low-rate sources and per-source saturating drop counters.
//   clk250_i    250 MHz trigger clock
//   rst_n_i     asynchronous active-low reset
//   tif         trigger path (trig_i, src_en_i, holdoff_i, dead_i in;
//               trig_o, source_o, pending_o, busy_o out)
//   drop_sel_i  drop counter select
//   drop_cnt_o  selected drop counter, registered
//   clr_cnt_i   synchronous clear of all drop counters
module anita3_trigger_scheduler
  import anita3_trig_pkg::*;
#(
  parameter int unsigned        NUM_SRC    = 4,
  parameter int unsigned        HOLD_W     = 16,
  parameter logic [NUM_SRC-1:0] QUEUE_MASK = QUEUE_MASK_DEF,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic                        clk250_i,
  input  logic                        rst_n_i,
  anita3_trigger_scheduler_if.slave   tif,
  input  logic [1:0]                  drop_sel_i,
  output logic [CNT_W-1:0]            drop_cnt_o,
  input  logic                        clr_cnt_i
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state, state_n;
  logic [SRC_W-1:0]   winner, winner_n;
  logic [NUM_SRC-1:0] pending, pending_n;
  logic [NUM_SRC-1:0] req, grant, drop;
  logic [HOLD_W-1:0]  hcnt;
  logic [SRC_W-1:0]   source_q;
  logic               go;
  logic               found;
  logic [CNT_W-1:0]   cnt [NUM_SRC];

  // Request evaluation and lowest-index priority encoder.
  always_comb begin
    req      = (tif.trig_i | pending) & tif.src_en_i;
    winner_n = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        winner_n = i[SRC_W-1:0];
        found    = 1'b1;
      end
    end
    go    = (state == ST_IDLE) && !tif.dead_i && (|req);
    grant = go ? (NUM_SRC'(1) << winner_n) : '0;
  end

  // A granted source leaves the queue. A fresh request is dropped if its
  // source is already pending (no double queue), or if it neither wins this
  // cycle nor is queueable. Disabled sources lose their pending bit silently.
  always_comb begin
    pending_n = tif.src_en_i & ~grant & (pending | (tif.trig_i & QUEUE_MASK));
    drop      = tif.src_en_i & tif.trig_i & (pending | (~grant & ~QUEUE_MASK));
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (go) state_n = ST_ISSUE;
      ST_ISSUE:   state_n = (tif.holdoff_i == '0) ? ST_IDLE : ST_HOLDOFF;
      ST_HOLDOFF: if (hcnt == HOLD_W'(1)) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      winner     <= '0;
      source_q   <= '0;
      hcnt       <= '0;
      pending    <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (go) winner <= winner_n;
      // holdoff_i is sampled only once per issue; later changes are ignored.
      if (state == ST_ISSUE) begin
        source_q <= winner;
        hcnt     <= tif.holdoff_i;
      end else if (state == ST_HOLDOFF) begin
        hcnt <= hcnt - 1'b1;
      end
      pending    <= pending_n;
      drop_cnt_o <= cnt[drop_sel_i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop
    anita3_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk250_i),
      .rst_n_i (rst_n_i),
      .inc_i   (drop[g]),
      .clr_i   (clr_cnt_i),
      .cnt_o   (cnt[g])
    );
  end

  assign tif.trig_o    = (state == ST_ISSUE) ? (NUM_SRC'(1) << winner) : '0;
  assign tif.source_o  = source_q;
  assign tif.pending_o = pending;
  assign tif.busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_anita3_trigger_scheduler.sv
module tb_anita3_trigger_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  drop_sel = '0;
  logic [15:0] drop_cnt;
  logic        clr_cnt = 1'b0;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [3:0]  v;
    int unsigned at;
  } exp_t;

  exp_t sb[$];

  anita3_trigger_scheduler_if #(.NUM_SRC(4), .HOLD_W(16)) intf ();

  anita3_trigger_scheduler #(
    .NUM_SRC    (4),
    .HOLD_W     (16),
    .QUEUE_MASK (4'b1110),
    .CNT_W      (16)
  ) dut (
    .clk250_i   (clk),
    .rst_n_i    (rst_n),
    .tif        (intf),
    .drop_sel_i (drop_sel),
    .drop_cnt_o (drop_cnt),
    .clr_cnt_i  (clr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_trig(input logic [3:0] v, input int unsigned at);
    exp_t e;
    e.v  = v;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (intf.busy_o && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(intf.busy_o), 32'd0);
  endtask

  // Scoreboard consumer: every trig_o pulse must match the oldest expectation
  // in both value and cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (intf.trig_o !== 4'b0000) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL unexpected_trig: observed %b at cycle %0d expected none", intf.trig_o, cyc);
      end else begin
        e = sb.pop_front();
        assert (intf.trig_o === e.v && cyc == e.at) else begin
          fails++;
          $error("FAIL trig_o: observed %b at cycle %0d expected %b at cycle %0d",
                 intf.trig_o, cyc, e.v, e.at);
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int unsigned m;

    intf.trig_i    = '0;
    intf.src_en_i  = 4'b1111;
    intf.holdoff_i = '0;
    intf.dead_i    = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_trig",    32'(intf.trig_o),    32'd0);
    check("rst_source",  32'(intf.source_o),  32'd0);
    check("rst_pending", 32'(intf.pending_o), 32'd0);
    check("rst_busy",    32'(intf.busy_o),    32'd0);
    check("rst_dropcnt", 32'(drop_cnt),       32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single soft trigger, holdoff 10
    intf.holdoff_i = 16'd10;
    intf.trig_i    = 4'b1000;
    expect_trig(4'b1000, cyc + 1);
    busy_cnt = 0;
    tick();
    intf.trig_i = '0;
    if (intf.busy_o) busy_cnt++;
    repeat (19) begin
      tick();
      if (intf.busy_o) busy_cnt++;
    end
    check("t1_busy_cycles", 32'(busy_cnt),       32'd11);
    check("t1_pending",     32'(intf.pending_o), 32'd0);
    check("t1_source",      32'(intf.source_o),  32'd3);

    // 2: all four at once, holdoff 0 -> issued in priority order every 2 cycles
    intf.holdoff_i = 16'd0;
    intf.trig_i    = 4'b1111;
    m = cyc;
    expect_trig(4'b0001, m + 1);
    expect_trig(4'b0010, m + 3);
    expect_trig(4'b0100, m + 5);
    expect_trig(4'b1000, m + 7);
    tick();
    intf.trig_i = '0;
    check("t2_pending", 32'(intf.pending_o), 32'b1110);
    repeat (10) tick();
    wait_idle(20);
    check("t2_source", 32'(intf.source_o), 32'd3);
    for (int s = 0; s < 4; s++) begin
      drop_sel = 2'(s);
      tick();
      check($sformatf("t2_drop%0d", s), 32'(drop_cnt), 32'd0);
    end

    // 3: RF during holdoff is dropped and counted
    intf.holdoff_i = 16'd20;
    drop_sel       = 2'd0;
    intf.trig_i    = 4'b1000;
    expect_trig(4'b1000, cyc + 1);
    tick();
    intf.trig_i = '0;
    repeat (3) tick();
    intf.trig_i = 4'b0001;
    tick();
    intf.trig_i = '0;
    tick();
    check("t3_rf_drop", 32'(drop_cnt), 32'd1);
    check("t3_pending", 32'(intf.pending_o), 32'd0);
    wait_idle(40);

    // 4: dead gates issue; queued PPS1 goes out right after dead falls
    intf.holdoff_i = 16'd2;
    intf.dead_i    = 1'b1;
    intf.trig_i    = 4'b0010;
    tick();
    intf.trig_i = '0;
    check("t4_pending_set", 32'(intf.pending_o), 32'b0010);
    repeat (5) tick();
    check("t4_pending_hold", 32'(intf.pending_o), 32'b0010);
    intf.dead_i = 1'b0;
    expect_trig(4'b0010, cyc + 1);
    tick();
    check("t4_pending_clr", 32'(intf.pending_o), 32'd0);
    wait_idle(10);

    // 5a: second PPS2 request while pending -> single drop
    drop_sel       = 2'd2;
    intf.dead_i    = 1'b1;
    intf.trig_i    = 4'b0100;
    tick();
    intf.trig_i = '0;
    tick();
    intf.trig_i = 4'b0100;
    tick();
    intf.trig_i = '0;
    tick();
    check("t5_pending", 32'(intf.pending_o), 32'b0100);
    check("t5_pps2_drop", 32'(drop_cnt), 32'd1);
    intf.dead_i = 1'b0;
    expect_trig(4'b0100, cyc + 1);
    tick();
    wait_idle(10);

    // 5b: RF saturation, clear, clear-beats-increment
    drop_sel    = 2'd0;
    intf.dead_i = 1'b1;
    intf.trig_i = 4'b0001;
    repeat (70000) tick();
    intf.trig_i = '0;
    tick();
    tick();
    check("t5_saturate", 32'(drop_cnt), 32'hFFFF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tick();
    check("t5_clear", 32'(drop_cnt), 32'd0);
    intf.trig_i = 4'b0001;
    clr_cnt     = 1'b1;
    tick();
    intf.trig_i = '0;
    clr_cnt     = 1'b0;
    tick();
    tick();
    check("t5_clear_wins", 32'(drop_cnt), 32'd0);
    intf.dead_i = 1'b0;

    // 5c: disabled source is ignored and not counted
    intf.src_en_i = 4'b1110;
    intf.trig_i   = 4'b0001;
    tick();
    intf.trig_i = '0;
    tick();
    tick();
    check("t5_disabled_drop", 32'(drop_cnt), 32'd0);
    intf.src_en_i = 4'b1111;

    // 6: async reset mid-holdoff with soft pending
    intf.holdoff_i = 16'd50;
    intf.trig_i    = 4'b0100;
    expect_trig(4'b0100, cyc + 1);
    tick();
    intf.trig_i = '0;
    repeat (3) tick();
    intf.trig_i = 4'b1000;
    tick();
    intf.trig_i = '0;
    check("t6_pending", 32'(intf.pending_o), 32'b1000);
    check("t6_busy",    32'(intf.busy_o),    32'd1);
    check("t6_source",  32'(intf.source_o),  32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_trig",    32'(intf.trig_o),    32'd0);
    check("t6_rst_source",  32'(intf.source_o),  32'd0);
    check("t6_rst_pending", 32'(intf.pending_o), 32'd0);
    check("t6_rst_busy",    32'(intf.busy_o),    32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    check("t6_post_pending", 32'(intf.pending_o), 32'd0);
    check("t6_post_busy",    32'(intf.busy_o),    32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
